// File: rtl/stack_op_sequencer.sv
// Sequencer for PUSH/POP/LOAD/CLEAR between the control unit, the SP register and the scratch RAM.
// Optional high-water tracking is enabled with `define STACK_HIGH_WATER_EN.
module stack_op_sequencer #(
  parameter int DW        = 10,
  parameter int DEPTH_MAX = 256
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic [1:0]    OP,
  input  logic [DW-1:0] DATA_IN,
  input  logic [7:0]    SP_IN,
  input  logic [DW-1:0] SCR_DATA_RD,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [DW-1:0] DATA_OUT,
  output logic [8:0]    DEPTH,
  output logic          SP_LD,
  output logic          SP_INCR,
  output logic          SP_DECR,
  output logic          SP_RST,
  output logic [7:0]    SP_DATA_OUT,
  output logic [7:0]    SCR_ADDR,
  output logic          SCR_WE,
  output logic [DW-1:0] SCR_DATA_WR,
  output logic [8:0]    HIGH_WATER
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_POP_WAIT = 2'd2,
    S_FIN      = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  localparam logic [8:0] LP_MAX = 9'(DEPTH_MAX);

  state_t        r_state;
  state_t        w_nstate;
  op_t           r_op;
  logic [DW-1:0] r_data;
  logic          r_err;
  logic [8:0]    r_depth;
  logic [DW-1:0] r_data_out;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = (r_depth < LP_MAX);
  assign w_pop_ok  = (r_depth != '0);

  // All strobes are decoded from registered state so RST removes them asynchronously.
  always_comb begin
    w_nstate    = r_state;
    SP_LD       = 1'b0;
    SP_INCR     = 1'b0;
    SP_DECR     = 1'b0;
    SP_RST      = 1'b0;
    SP_DATA_OUT = '0;
    SCR_ADDR    = '0;
    SCR_WE      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ) w_nstate = S_EXEC;
      end
      S_EXEC: begin
        w_nstate = S_FIN;
        case (r_op)
          OP_PUSH: begin
            if (w_push_ok) begin
              SCR_ADDR = SP_IN - 8'd1;
              SCR_WE   = 1'b1;
              SP_DECR  = 1'b1;
            end
          end
          OP_POP: begin
            if (w_pop_ok) begin
              SCR_ADDR = SP_IN;
              w_nstate = S_POP_WAIT;
            end
          end
          OP_LOAD: begin
            SP_LD       = 1'b1;
            SP_DATA_OUT = r_data[7:0];
          end
          OP_CLEAR: begin
            SP_RST = 1'b1;
          end
          default: ;
        endcase
      end
      S_POP_WAIT: begin
        SCR_ADDR = SP_IN;
        SP_INCR  = 1'b1;
        w_nstate = S_FIN;
      end
      S_FIN: begin
        w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_op       <= OP_PUSH;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_depth    <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_nstate;
      case (r_state)
        S_IDLE: begin
          if (REQ) begin
            r_op   <= op_t'(OP);
            r_data <= DATA_IN;
            r_err  <= 1'b0;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_PUSH: begin
              if (w_push_ok) r_depth <= r_depth + 9'd1;
              else           r_err   <= 1'b1;
            end
            OP_POP: begin
              if (!w_pop_ok) r_err <= 1'b1;
            end
            OP_LOAD, OP_CLEAR: r_depth <= '0;
            default: ;
          endcase
        end
        S_POP_WAIT: begin
          r_data_out <= SCR_DATA_RD;
          r_depth    <= r_depth - 9'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_HIGH_WATER_EN
  logic [8:0] r_hw;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hw <= '0;
    end else if (r_state == S_EXEC && r_op == OP_PUSH && w_push_ok &&
                 (r_depth + 9'd1) > r_hw) begin
      r_hw <= r_depth + 9'd1;
    end
  end
  assign HIGH_WATER = r_hw;
`else
  assign HIGH_WATER = '0;
`endif

  assign BUSY        = (r_state != S_IDLE);
  assign DONE        = (r_state == S_FIN);
  assign ERR         = (r_state == S_FIN) && r_err;
  assign DATA_OUT    = r_data_out;
  assign DEPTH       = r_depth;
  assign SCR_DATA_WR = r_data;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboard bench for stack_op_sequencer with SP-register and scratch-RAM models.
module tb_stack_op_sequencer;

  localparam int DW = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ = 1'b0;
  logic [1:0]    OP = 2'b00;
  logic [DW-1:0] DATA_IN = '0;
  logic [7:0]    SP_IN;
  logic [DW-1:0] SCR_DATA_RD;
  logic          BUSY, DONE, ERR;
  logic [DW-1:0] DATA_OUT;
  logic [8:0]    DEPTH;
  logic          SP_LD, SP_INCR, SP_DECR, SP_RST;
  logic [7:0]    SP_DATA_OUT, SCR_ADDR;
  logic          SCR_WE;
  logic [DW-1:0] SCR_DATA_WR;
  logic [8:0]    HIGH_WATER;

  stack_op_sequencer #(.DW(DW), .DEPTH_MAX(256)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .DATA_IN(DATA_IN),
    .SP_IN(SP_IN), .SCR_DATA_RD(SCR_DATA_RD), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .DATA_OUT(DATA_OUT), .DEPTH(DEPTH), .SP_LD(SP_LD),
    .SP_INCR(SP_INCR), .SP_DECR(SP_DECR), .SP_RST(SP_RST),
    .SP_DATA_OUT(SP_DATA_OUT), .SCR_ADDR(SCR_ADDR), .SCR_WE(SCR_WE),
    .SCR_DATA_WR(SCR_DATA_WR), .HIGH_WATER(HIGH_WATER)
  );

  always #5 CLK = ~CLK;

  // Environment: SP register and synchronous-read scratch RAM.
  logic [7:0]    sp = 8'h5A;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd = '0;
  assign SP_IN       = sp;
  assign SCR_DATA_RD = rd;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge CLK) begin
    if (SP_RST)       sp <= 8'h00;
    else if (SP_LD)   sp <= SP_DATA_OUT;
    else if (SP_INCR) sp <= sp + 8'd1;
    else if (SP_DECR) sp <= sp - 8'd1;
    if (SCR_WE) mem[SCR_ADDR] <= SCR_DATA_WR;
    rd <= mem[SCR_ADDR];
  end

  typedef struct {
    logic          err;
    logic [DW-1:0] dout;
    logic [8:0]    depth;
    logic [8:0]    hw;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int n_ld = 0, n_incr = 0, n_decr = 0, n_rst = 0, n_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: strobe counting, invariants, and scoreboard compare on DONE.
  always @(negedge CLK) begin
    if (!RST) begin
      n_ld   += int'(SP_LD);
      n_incr += int'(SP_INCR);
      n_decr += int'(SP_DECR);
      n_rst  += int'(SP_RST);
      n_we   += int'(SCR_WE);
      if ($countones({SP_LD, SP_INCR, SP_DECR, SP_RST}) > 1) viol++;
      if (ERR && !DONE) viol++;
      if (SCR_WE && (!BUSY || DONE)) viol++;
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("err",        {31'd0, ERR},      {31'd0, e.err});
          chk("data_out",   {22'd0, DATA_OUT}, {22'd0, e.dout});
          chk("depth",      {23'd0, DEPTH},    {23'd0, e.depth});
          chk("high_water", {23'd0, HIGH_WATER}, {23'd0, e.hw});
        end
      end
    end
  end

  // Reference model of the stack contents and counters.
  logic [DW-1:0] m_stk[$];
  int            m_depth = 0;
  logic [DW-1:0] m_dout  = '0;
  int            m_hw    = 0;

  logic [7:0]    c_addr, c_spdata;
  logic          c_we, c_decr;
  logic [DW-1:0] c_wr;

  task automatic do_op(input logic [1:0] op, input logic [DW-1:0] d, input bit hold);
    exp_t e;
    int   lat, exp_lat;
    bit   err;
    err = 1'b0;
    case (op)
      2'b00: if (m_depth < 256) begin
               m_stk.push_back(d); m_depth++;
               if (m_depth > m_hw) m_hw = m_depth;
             end else err = 1'b1;
      2'b01: if (m_depth > 0) begin
               m_dout = m_stk.pop_back(); m_depth--;
             end else err = 1'b1;
      default: begin m_stk.delete(); m_depth = 0; end
    endcase
    exp_lat = (op == 2'b01 && !err) ? 3 : 2;
    e.err   = err;
    e.dout  = m_dout;
    e.depth = 9'(m_depth);
`ifdef STACK_HIGH_WATER_EN
    e.hw = 9'(m_hw);
`else
    e.hw = '0;
`endif
    sb.push_back(e);
    @(negedge CLK);
    REQ = 1'b1; OP = op; DATA_IN = d;
    @(posedge CLK); #1;
    if (!hold) REQ = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        c_addr = SCR_ADDR; c_we = SCR_WE; c_wr = SCR_DATA_WR;
        c_decr = SP_DECR;  c_spdata = SP_DATA_OUT;
      end
      if (DONE) break;
    end
    REQ = 1'b0;
    if (!DONE) chk("done_timeout", 32'd1, 32'd0);
    else       chk("latency", lat, exp_lat);
  endtask

  int s_decr, s_incr, s_we, s_ld;
  logic [7:0] sp_hold;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_outs", {22'd0, BUSY, DONE, ERR, SP_LD, SP_INCR, SP_DECR, SP_RST, SCR_WE, 2'b00},
        32'd0);
    chk("rst_vals", {DATA_OUT, DEPTH, SCR_ADDR, SP_DATA_OUT[4:0]}, 32'd0);
    chk("rst_hw", {23'd0, HIGH_WATER}, 32'd0);
    @(negedge CLK); RST = 1'b0;

    // CLEAR from arbitrary SP
    do_op(2'b11, '0, 1'b0);
    chk("clear_sp_rst_count", n_rst, 1);
    @(posedge CLK); #1;
    chk("clear_sp", {24'd0, sp}, 32'h00);

    // PUSH 0x2AB at SP=0x00 wraps address to 0xFF
    do_op(2'b00, 10'h2AB, 1'b0);
    chk("push_addr", {24'd0, c_addr}, 32'hFF);
    chk("push_we", {31'd0, c_we}, 32'd1);
    chk("push_wr", {22'd0, c_wr}, 32'h2AB);
    chk("push_decr", {31'd0, c_decr}, 32'd1);

    // POP returns it
    s_incr = n_incr;
    do_op(2'b01, '0, 1'b0);
    chk("pop_incr_count", n_incr - s_incr, 1);
    @(posedge CLK); #1;
    chk("pop_sp", {24'd0, sp}, 32'h00);

    // POP on empty stack
    s_incr = n_incr; s_decr = n_decr; s_we = n_we; s_ld = n_ld;
    do_op(2'b01, '0, 1'b0);
    chk("underflow_strobes", (n_incr - s_incr) + (n_decr - s_decr) + (n_we - s_we) + (n_ld - s_ld), 0);

    // LOAD uses low 8 bits
    do_op(2'b10, 10'h3C5, 1'b0);
    chk("load_spdata", {24'd0, c_spdata}, 32'hC5);
    @(posedge CLK); #1;
    chk("load_sp", {24'd0, sp}, 32'hC5);

    // LIFO ordering
    do_op(2'b00, 10'h111, 1'b0);
    do_op(2'b00, 10'h222, 1'b0);
    do_op(2'b00, 10'h333, 1'b0);
    do_op(2'b01, '0, 1'b0);
    do_op(2'b01, '0, 1'b0);
    do_op(2'b01, '0, 1'b0);
    @(posedge CLK); #1;
    chk("lifo_sp", {24'd0, sp}, 32'hC5);

    // Fill to DEPTH_MAX, then overflow
    do_op(2'b11, '0, 1'b0);
    s_decr = n_decr;
    for (int i = 0; i < 256; i++) do_op(2'b00, DW'(i + 7), 1'b0);
    s_we = n_we;
    do_op(2'b00, 10'h3FF, 1'b0);
    chk("full_decr_count", n_decr - s_decr, 256);
    chk("overflow_no_we", n_we - s_we, 0);
    do_op(2'b01, '0, 1'b0);
    do_op(2'b10, 10'h000, 1'b0);

    // REQ held across BUSY starts only one op
    s_decr = n_decr;
    do_op(2'b00, 10'h155, 1'b1);
    repeat (4) @(negedge CLK);
    chk("held_req_busy", {31'd0, BUSY}, 32'd0);
    chk("held_req_decr", n_decr - s_decr, 1);

    // Reset during POP_WAIT
    @(negedge CLK);
    REQ = 1'b1; OP = 2'b01;
    @(posedge CLK); #1; REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("popwait_incr", {31'd0, SP_INCR}, 32'd1);
    sp_hold = sp;
    RST = 1'b1; #1;
    chk("abort_incr", {31'd0, SP_INCR}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_dout", {22'd0, DATA_OUT}, 32'd0);
    chk("abort_depth", {23'd0, DEPTH}, 32'd0);
    chk("abort_hw", {23'd0, HIGH_WATER}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_sp", {24'd0, sp}, {24'd0, sp_hold});
    @(negedge CLK); RST = 1'b0;
    m_stk.delete(); m_depth = 0; m_dout = '0; m_hw = 0;
    do_op(2'b11, '0, 1'b0);

    repeat (3) @(negedge CLK);
    chk("invariants", viol, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
